// File: rtl/m3_key_cmd_decode_pkg.sv
// m3_keyPkg: shared key indices, FSM state codes and timing defaults for the motor key decoder
package m3_keyPkg;
  localparam int K_START   = 0;
  localparam int K_FSTOP   = 1;
  localparam int K_INV     = 2;
  localparam int K_SPD_INC = 3;
  localparam int K_SPD_DEC = 4;
  localparam int K_PWR_INC = 5;
  localparam int K_PWR_DEC = 6;
  localparam int N_KEYS    = 7;
  localparam logic [3:0] DEB_TICKS_DEF = 4'd3;
  localparam logic [3:0] REL_TICKS_DEF = 4'd5;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_FSTOP = 2'd2} state_t;
endpackage

// File: rtl/m3_key_cmd_decode_debounce.sv
// m3_keyDebounce: one key -- 2-FF sync, tick-sampled debounce counter, stable level and press pulse
// Ports: clkI/nRstI clock and async active-low reset; tickI 100 Hz sample strobe;
// keyNi raw active-low key; stableO debounced level (1 = pressed); pressO 1-cycle pulse on press.
module m3_keyDebounce
  import m3_keyPkg::*;
#(
  parameter logic [3:0] DEB_TICKS = DEB_TICKS_DEF
) (
  input  logic clkI,
  input  logic nRstI,
  input  logic tickI,
  input  logic keyNi,
  output logic stableO,
  output logic pressO
);
  logic [1:0] sync_q;
  logic [3:0] cnt_q, cnt_d, cnt_inc;
  logic       stable_q, stable_d, press_q, differ, flip;
  always_comb begin
    differ   = ~sync_q[1] != stable_q;
    cnt_inc  = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;
    flip     = tickI && differ && (cnt_inc >= DEB_TICKS);
    cnt_d    = !tickI ? cnt_q : (!differ || flip) ? 4'd0 : cnt_inc;
    stable_d = stable_q ^ flip;
  end
  always_ff @(posedge clkI or negedge nRstI) begin
    if (!nRstI) begin
      sync_q   <= 2'b11;
      cnt_q    <= 4'd0;
      stable_q <= 1'b0;
      press_q  <= 1'b0;
    end else begin
      sync_q   <= {sync_q[0], keyNi};
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      press_q  <= flip & ~stable_q;
    end
  end
  assign stableO = stable_q;
  assign pressO  = press_q;
endmodule

// File: rtl/m3_key_cmd_decode.sv
// m3_key_cmd_decode: debounces seven motor keys and runs the idle/run/force-stop command FSM
// Ports: clkI 1 MHz clock; nRstI async active-low reset; clk100hzI 100 Hz sample wave (data);
// keyNi raw active-low keys; m3startO run request (0 = run); m3forceStopO force-stop flag;
// m3invRotateO direction level; m3speed*/m3power* debounced hold levels, live only while running.
module m3_key_cmd_decode
  import m3_keyPkg::*;
#(
  parameter logic [3:0] DEB_TICKS = DEB_TICKS_DEF,
  parameter logic [3:0] REL_TICKS = REL_TICKS_DEF
) (
  input  logic       clkI,
  input  logic       nRstI,
  input  logic       clk100hzI,
  input  logic [6:0] keyNi,
  output logic       m3startO,
  output logic       m3forceStopO,
  output logic       m3invRotateO,
  output logic       m3speedINCo,
  output logic       m3speedDECo,
  output logic       m3powerINCo,
  output logic       m3powerDECo
);
  logic [2:0]        c100_q;
  logic              tick, any_key, run_d;
  logic [N_KEYS-1:0] stable, press;
  logic [3:0]        rel_q, rel_d, rel_inc;
  state_t            state_q, state_d;
  logic              inv_q, inv_d, start_q, fstop_q, spd_inc_q, spd_dec_q, pwr_inc_q, pwr_dec_q;
  assign tick = c100_q[1] & ~c100_q[2];
  for (genvar i = 0; i < N_KEYS; i++) begin : g_key
    m3_keyDebounce #(.DEB_TICKS(DEB_TICKS)) u_deb (
      .clkI   (clkI),
      .nRstI  (nRstI),
      .tickI  (tick),
      .keyNi  (keyNi[i]),
      .stableO(stable[i]),
      .pressO (press[i])
    );
  end
  // a press pulse always coincides with its stable bit; OR-ing it in keeps the release timer honest
  assign any_key = |stable | |press;
  always_comb begin
    state_d = state_q;
    inv_d   = inv_q;
    rel_d   = 4'd0;
    rel_inc = (rel_q == 4'hF) ? rel_q : rel_q + 4'd1;
    if (state_q == ST_IDLE) begin
      state_d = press[K_START] ? ST_RUN : ST_IDLE;
      inv_d   = inv_q ^ press[K_INV];
    end else if (state_q == ST_RUN) begin
      state_d = press[K_START] ? ST_IDLE : ST_RUN;
    end else begin
      rel_d = any_key ? 4'd0 : tick ? rel_inc : rel_q;
      if (!any_key && tick && rel_inc >= REL_TICKS) begin
        state_d = ST_IDLE;
        rel_d   = 4'd0;
      end
    end
    if (press[K_FSTOP]) state_d = ST_FSTOP;
    run_d = state_d == ST_RUN;
  end
  always_ff @(posedge clkI or negedge nRstI) begin
    if (!nRstI) begin
      c100_q    <= 3'b000;
      state_q   <= ST_IDLE;
      rel_q     <= 4'd0;
      inv_q     <= 1'b0;
      start_q   <= 1'b1;
      fstop_q   <= 1'b0;
      spd_inc_q <= 1'b0;
      spd_dec_q <= 1'b0;
      pwr_inc_q <= 1'b0;
      pwr_dec_q <= 1'b0;
    end else begin
      c100_q    <= {c100_q[1:0], clk100hzI};
      state_q   <= state_d;
      rel_q     <= rel_d;
      inv_q     <= inv_d;
      start_q   <= !run_d;
      fstop_q   <= state_d == ST_FSTOP;
      spd_inc_q <= run_d & stable[K_SPD_INC] & ~stable[K_SPD_DEC];
      spd_dec_q <= run_d & stable[K_SPD_DEC] & ~stable[K_SPD_INC];
      pwr_inc_q <= run_d & stable[K_PWR_INC] & ~stable[K_PWR_DEC];
      pwr_dec_q <= run_d & stable[K_PWR_DEC] & ~stable[K_PWR_INC];
    end
  end
  assign m3startO     = start_q;
  assign m3forceStopO = fstop_q;
  assign m3invRotateO = inv_q;
  assign m3speedINCo  = spd_inc_q;
  assign m3speedDECo  = spd_dec_q;
  assign m3powerINCo  = pwr_inc_q;
  assign m3powerDECo  = pwr_dec_q;
endmodule

// File: tb/tb_m3_key_cmd_decode.sv
// tb_m3_key_cmd_decode: directed self-checking bench for the key command decoder
`timescale 1ns/1ps
module tb_m3_key_cmd_decode;
  logic       clkI = 1'b0, nRstI = 1'b0, clk100hzI = 1'b0;
  logic [6:0] keyNi = 7'h7F;
  logic       m3startO, m3forceStopO, m3invRotateO, m3speedINCo, m3speedDECo, m3powerINCo, m3powerDECo;
  int         tests = 0, fails = 0;
  m3_key_cmd_decode dut (
    .clkI        (clkI),
    .nRstI       (nRstI),
    .clk100hzI   (clk100hzI),
    .keyNi       (keyNi),
    .m3startO    (m3startO),
    .m3forceStopO(m3forceStopO),
    .m3invRotateO(m3invRotateO),
    .m3speedINCo (m3speedINCo),
    .m3speedDECo (m3speedDECo),
    .m3powerINCo (m3powerINCo),
    .m3powerDECo (m3powerDECo)
  );
  always #5 clkI = ~clkI;
  always #100 clk100hzI = ~clk100hzI;
  task automatic check(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask
  task automatic hold(input int t);
    repeat (t * 20) @(posedge clkI);
    @(negedge clkI);
  endtask
  initial begin
    int n;
    repeat (3) @(negedge clkI);
    check("rst_start", m3startO, 1'b1);
    check("rst_fstop", m3forceStopO, 1'b0);
    check("rst_inv", m3invRotateO, 1'b0);
    check("rst_spd_inc", m3speedINCo, 1'b0);
    check("rst_pwr_dec", m3powerDECo, 1'b0);
    nRstI = 1'b1;
    hold(2);
    keyNi[2] = 1'b0;
    hold(5);
    check("idle_inv_toggle", m3invRotateO, 1'b1);
    keyNi = 7'h7F;
    hold(5);
    keyNi[0] = 1'b0;
    n = 0;
    while (m3startO !== 1'b0 && n < 70) begin
      @(negedge clkI);
      n++;
    end
    check("start_latency", m3startO, 1'b0);
    hold(2);
    keyNi = 7'h7F;
    hold(5);
    check("run_after_release", m3startO, 1'b0);
    keyNi[0] = 1'b0;
    repeat (35) @(negedge clkI);
    keyNi = 7'h7F;
    hold(5);
    check("glitch_start", m3startO, 1'b0);
    check("glitch_fstop", m3forceStopO, 1'b0);
    check("glitch_spd", m3speedINCo, 1'b0);
    keyNi[2] = 1'b0;
    hold(5);
    check("run_inv_ignored", m3invRotateO, 1'b1);
    keyNi = 7'h7F;
    hold(5);
    keyNi[3] = 1'b0;
    keyNi[6] = 1'b0;
    hold(5);
    check("spd_inc_only", m3speedINCo, 1'b1);
    check("spd_dec_off", m3speedDECo, 1'b0);
    check("pwr_dec_only", m3powerDECo, 1'b1);
    check("pwr_inc_off", m3powerINCo, 1'b0);
    keyNi[4] = 1'b0;
    hold(5);
    check("both_spd_inc", m3speedINCo, 1'b0);
    check("both_spd_dec", m3speedDECo, 1'b0);
    keyNi[3] = 1'b1;
    hold(5);
    check("spd_dec_only", m3speedDECo, 1'b1);
    check("spd_inc_after", m3speedINCo, 1'b0);
    keyNi[0] = 1'b0;
    hold(5);
    check("idle_start", m3startO, 1'b1);
    check("idle_spd_dec", m3speedDECo, 1'b0);
    check("idle_pwr_dec", m3powerDECo, 1'b0);
    keyNi = 7'h7F;
    hold(5);
    keyNi[0] = 1'b0;
    hold(5);
    keyNi = 7'h7F;
    hold(5);
    check("rerun", m3startO, 1'b0);
    keyNi = 7'h7C;
    hold(5);
    check("fstop_set", m3forceStopO, 1'b1);
    check("fstop_start", m3startO, 1'b1);
    keyNi = 7'h7F;
    hold(5);
    check("fstop_still", m3forceStopO, 1'b1);
    hold(7);
    check("fstop_left", m3forceStopO, 1'b0);
    check("fstop_idle", m3startO, 1'b1);
    keyNi[0] = 1'b0;
    hold(5);
    keyNi = 7'h7F;
    hold(5);
    keyNi[3] = 1'b0;
    hold(5);
    check("pre_rst_spd", m3speedINCo, 1'b1);
    #2 nRstI = 1'b0;
    #1;
    check("async_rst_start", m3startO, 1'b1);
    check("async_rst_spd", m3speedINCo, 1'b0);
    check("async_rst_inv", m3invRotateO, 1'b0);
    check("async_rst_fstop", m3forceStopO, 1'b0);
    keyNi = 7'h7F;
    @(negedge clkI);
    nRstI = 1'b1;
    hold(2);
    keyNi[0] = 1'b0;
    repeat (35) @(negedge clkI);
    keyNi = 7'h7F;
    hold(5);
    check("short_after_rst", m3startO, 1'b1);
    keyNi[0] = 1'b0;
    repeat (45) @(negedge clkI);
    nRstI = 1'b0;
    keyNi = 7'h7F;
    repeat (3) @(negedge clkI);
    nRstI = 1'b1;
    hold(5);
    check("mid_deb_rst", m3startO, 1'b1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
